frame_bank_arb: RTL and testbench

FRAME_BANK_ARB -- requirements
Module: frame_bank_arb

---
 rtl/frame_bank_arb.sv | 184 ++++++++++++++++++
 tb/tb_frame_bank_arb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_arb.sv
// frame_bank_arb: rotates NUM_BANKS frame buffers between an async writer and reader. Stats need FRAME_BANK_STATS_EN.
// Latency: bank outputs move 4 clk after a sync input edge (2 sync flops, edge register, state register).
// Backpressure: none; events are lost while frozen, and overflow is resolved by dropping frames.
module frame_bank_arb #(
    parameter int NUM_BANKS = 3,
    parameter int BANK_W    = 2,
    parameter int MODE      = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_133,
    input  logic              wr_sync,
    input  logic              rd_sync,
    input  logic              freeze,
    output logic [BANK_W-1:0] wr_bank,
    output logic [BANK_W-1:0] rd_bank,
    output logic [BANK_W:0]   full_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  rept_cnt
);
    typedef enum logic [1:0] {B_FREE, B_WRITING, B_FULL, B_READING} bank_st_t;

    logic [1:0] wr_meta, rd_meta, fill;
    logic       wr_prev, rd_prev, wr_arm, rd_arm, wr_evt, rd_evt;

    always_ff @(posedge clk or posedge rst_133) begin
        if (rst_133) begin
            fill    <= '0;
            wr_meta <= '0;
            rd_meta <= '0;
            wr_prev <= 1'b0;
            rd_prev <= 1'b0;
            wr_arm  <= 1'b0;
            rd_arm  <= 1'b0;
            wr_evt  <= 1'b0;
            rd_evt  <= 1'b0;
        end else begin
            fill    <= {fill[0], 1'b1};
            wr_meta <= {wr_meta[0], wr_sync};
            rd_meta <= {rd_meta[0], rd_sync};
            wr_prev <= wr_meta[1];
            rd_prev <= rd_meta[1];
            // an edge only counts once a genuine low has come through the synchroniser
            if (fill[1] && !wr_meta[1]) wr_arm <= 1'b1;
            if (fill[1] && !rd_meta[1]) rd_arm <= 1'b1;
            wr_evt  <= wr_arm & wr_meta[1] & ~wr_prev;
            rd_evt  <= rd_arm & rd_meta[1] & ~rd_prev;
        end
    end

    bank_st_t [NUM_BANKS-1:0]  st_q, st_d;
    logic [NUM_BANKS-1:0][2:0] age_q, age_d;
    logic [2:0]                seq_q, seq_d, rel, old_rel, sel_rel;
    logic [BANK_W-1:0]         wr_d, rd_d, free_idx, old_idx, sel_idx;
    logic                      free_hit, sel_hit, wr_go, rd_go, rept_inc;
    logic [3:0]                drop_inc;
    logic [BANK_W:0]           full_d;

    assign wr_go = wr_evt & ~freeze;
    assign rd_go = rd_evt & ~freeze;

    // ages are (seq - stamp) mod 8: FULL banks span at most 6 stamps, so larger means older
    always_comb begin
        st_d     = st_q;
        age_d    = age_q;
        seq_d    = seq_q;
        wr_d     = wr_bank;
        rd_d     = rd_bank;
        rel      = '0;
        old_rel  = '0;
        sel_rel  = '0;
        free_idx = '0;
        old_idx  = '0;
        sel_idx  = '0;
        free_hit = 1'b0;
        sel_hit  = 1'b0;
        rept_inc = 1'b0;
        drop_inc = '0;
        full_d   = '0;

        if (wr_go) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                rel = seq_q - age_q[i];
                if (st_q[i] == B_FREE && !free_hit) begin
                    free_hit = 1'b1;
                    free_idx = BANK_W'(i);
                end
                if (st_q[i] == B_FULL && rel > old_rel) begin
                    old_rel = rel;
                    old_idx = BANK_W'(i);
                end
            end
            if (free_hit || MODE == 0) begin
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (BANK_W'(i) == wr_bank) begin
                        st_d[i]  = B_FULL;
                        age_d[i] = seq_q;
                    end
                end
                seq_d = seq_q + 3'd1;
                wr_d  = free_hit ? free_idx : old_idx;
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (BANK_W'(i) == wr_d) st_d[i] = B_WRITING;
                end
            end
            if (!free_hit) drop_inc = 4'd1;
        end

        // reader sees the post-write bank picture, so it may grab the frame just completed
        if (rd_go) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                rel = seq_d - age_d[i];
                if (st_d[i] == B_FULL &&
                    (!sel_hit || ((MODE == 0) ? (rel < sel_rel) : (rel > sel_rel)))) begin
                    sel_hit = 1'b1;
                    sel_idx = BANK_W'(i);
                    sel_rel = rel;
                end
            end
            if (sel_hit) begin
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (BANK_W'(i) == rd_bank) begin
                        st_d[i] = B_FREE;
                    end else if (BANK_W'(i) == sel_idx) begin
                        st_d[i] = B_READING;
                    end else if (MODE == 0 && st_d[i] == B_FULL) begin
                        st_d[i]  = B_FREE;
                        drop_inc = drop_inc + 4'd1;
                    end
                end
                rd_d = sel_idx;
            end else begin
                rept_inc = 1'b1;
            end
        end

        for (int i = 0; i < NUM_BANKS; i++) begin
            if (st_d[i] == B_FULL) full_d = full_d + (BANK_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_133) begin
        if (rst_133) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                st_q[i]  <= (i == 0) ? B_READING : ((i == 1) ? B_WRITING : B_FREE);
                age_q[i] <= '0;
            end
            seq_q    <= '0;
            wr_bank  <= BANK_W'(1);
            rd_bank  <= '0;
            full_cnt <= '0;
        end else begin
            st_q     <= st_d;
            age_q    <= age_d;
            seq_q    <= seq_d;
            wr_bank  <= wr_d;
            rd_bank  <= rd_d;
            full_cnt <= full_d;
        end
    end

`ifdef FRAME_BANK_STATS_EN
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
        logic [CNT_W+3:0] s;
        s = (CNT_W+4)'(a) + (CNT_W+4)'(b);
        return (s > (CNT_W+4)'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst_133) begin
        if (rst_133) begin
            drop_cnt <= '0;
            rept_cnt <= '0;
        end else begin
            drop_cnt <= sat_add(drop_cnt, drop_inc);
            rept_cnt <= sat_add(rept_cnt, {3'b000, rept_inc});
        end
    end
`else
    logic stats_unused;
    assign stats_unused = ^{drop_inc, rept_inc};
    assign drop_cnt     = '0;
    assign rept_cnt     = '0;
`endif
endmodule

// File: tb/tb_frame_bank_arb.sv
// tb_frame_bank_arb: three arbiters (3 banks latest-frame, 4 and 8 banks in-order) on shared stimulus.
// Expected bank/counter values come from an ordered FULL-list model; directed steps then random events.
// Sync edges are held for many clocks so every edge is one clean event.
module tb_frame_bank_arb;
    logic clk = 1'b0;
    logic rst_133, wr_sync, rd_sync, freeze;

    logic [1:0] wr0, rd0, wr1, rd1;
    logic [2:0] full0, full1, wr2, rd2;
    logic [3:0] full2, drop0, rept0, drop1, rept1, drop2, rept2;

    frame_bank_arb #(.NUM_BANKS(3), .BANK_W(2), .MODE(0), .CNT_W(4)) u0 (
        .clk(clk), .rst_133(rst_133), .wr_sync(wr_sync), .rd_sync(rd_sync), .freeze(freeze),
        .wr_bank(wr0), .rd_bank(rd0), .full_cnt(full0), .drop_cnt(drop0), .rept_cnt(rept0));
    frame_bank_arb #(.NUM_BANKS(4), .BANK_W(2), .MODE(1), .CNT_W(4)) u1 (
        .clk(clk), .rst_133(rst_133), .wr_sync(wr_sync), .rd_sync(rd_sync), .freeze(freeze),
        .wr_bank(wr1), .rd_bank(rd1), .full_cnt(full1), .drop_cnt(drop1), .rept_cnt(rept1));
    frame_bank_arb #(.NUM_BANKS(8), .BANK_W(3), .MODE(1), .CNT_W(4)) u2 (
        .clk(clk), .rst_133(rst_133), .wr_sync(wr_sync), .rd_sync(rd_sync), .freeze(freeze),
        .wr_bank(wr2), .rd_bank(rd2), .full_cnt(full2), .drop_cnt(drop2), .rept_cnt(rept2));

    always #5 clk = ~clk;

    localparam int CMAX = 15;
    int NB[3] = '{3, 4, 8};
    int MD[3] = '{0, 1, 1};
    int m_wr[3], m_rd[3], m_drop[3], m_rept[3], nf[3];
    int ord[3][8];
    int n_chk = 0;
    int n_err = 0;

    function automatic int sat(int c, int n);
        return (c + n > CMAX) ? CMAX : c + n;
    endfunction

    function automatic bit in_full(int k, int b);
        for (int j = 0; j < nf[k]; j++) if (ord[k][j] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            m_wr[k] = 1; m_rd[k] = 0; nf[k] = 0; m_drop[k] = 0; m_rept[k] = 0;
        end
    endtask

    task automatic pop_front(int k);
        for (int j = 0; j < nf[k] - 1; j++) ord[k][j] = ord[k][j+1];
        nf[k]--;
    endtask

    task automatic m_write(int k);
        int f;
        ord[k][nf[k]] = m_wr[k];
        nf[k]++;
        f = -1;
        for (int b = 0; b < NB[k]; b++)
            if (f < 0 && b != m_rd[k] && !in_full(k, b)) f = b;
        if (f >= 0) begin
            m_wr[k] = f;
        end else begin
            m_drop[k] = sat(m_drop[k], 1);
            if (MD[k] == 0) begin
                m_wr[k] = ord[k][0];
                pop_front(k);
            end else begin
                nf[k]--;
            end
        end
    endtask

    task automatic m_read(int k);
        if (nf[k] > 0) begin
            if (MD[k] == 0) begin
                m_rd[k] = ord[k][nf[k]-1];
                m_drop[k] = sat(m_drop[k], nf[k] - 1);
                nf[k] = 0;
            end else begin
                m_rd[k] = ord[k][0];
                pop_front(k);
            end
        end else begin
            m_rept[k] = sat(m_rept[k], 1);
        end
    endtask

    task automatic chk(string tag, int obs, int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_inst(string tag, int k, int wr, int rd, int full, int drop, int rept);
        int ed, er;
        ed = m_drop[k];
        er = m_rept[k];
`ifndef FRAME_BANK_STATS_EN
        ed = 0;
        er = 0;
`endif
        chk($sformatf("%s u%0d wr_bank", tag, k), wr, m_wr[k]);
        chk($sformatf("%s u%0d rd_bank", tag, k), rd, m_rd[k]);
        chk($sformatf("%s u%0d full_cnt", tag, k), full, nf[k]);
        chk($sformatf("%s u%0d drop_cnt", tag, k), drop, ed);
        chk($sformatf("%s u%0d rept_cnt", tag, k), rept, er);
        chk($sformatf("%s u%0d banks_differ", tag, k), int'(wr != rd), 1);
    endtask

    task automatic check_all(string tag);
        check_inst(tag, 0, int'(wr0), int'(rd0), int'(full0), int'(drop0), int'(rept0));
        check_inst(tag, 1, int'(wr1), int'(rd1), int'(full1), int'(drop1), int'(rept1));
        check_inst(tag, 2, int'(wr2), int'(rd2), int'(full2), int'(drop2), int'(rept2));
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        #2 rst_133 = 1'b1;
        #1 m_reset();
        check_all(tag);
        @(negedge clk);
        rst_133 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic evt(bit w, bit r, bit frz);
        @(negedge clk);
        freeze  = frz;
        wr_sync = w;
        rd_sync = r;
        repeat (6) @(negedge clk);
        wr_sync = 1'b0;
        rd_sync = 1'b0;
        repeat (5) @(negedge clk);
        freeze = 1'b0;
        if (!frz) begin
            for (int k = 0; k < 3; k++) begin
                if (w) m_write(k);
                if (r) m_read(k);
            end
        end
    endtask

    initial begin
        bit w, r, f;
        rst_133 = 1'b1;
        wr_sync = 1'b0;
        rd_sync = 1'b0;
        freeze  = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_133 = 1'b0;
        repeat (4) @(negedge clk);

        // one write edge: exact update latency, then one read
        wr_sync = 1'b1;
        repeat (3) @(negedge clk);
        chk("latency_before", int'(wr0), 1);
        @(negedge clk);
        chk("latency_after", int'(wr0), 2);
        wr_sync = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 3; k++) m_write(k);
        check_all("wr_once");
        evt(1'b0, 1'b1, 1'b0);
        check_all("rd_once");

        // overflow with no reader
        do_reset("reset2");
        for (int i = 0; i < 3; i++) begin
            evt(1'b1, 1'b0, 1'b0);
            check_all($sformatf("overflow%0d", i));
        end

        // write and read in the same clock
        do_reset("reset3");
        evt(1'b1, 1'b1, 1'b0);
        check_all("same_clk");

        // in-order sequence and reader repeat
        do_reset("reset4");
        evt(1'b1, 1'b0, 1'b0); check_all("seq_w0");
        evt(1'b1, 1'b0, 1'b0); check_all("seq_w1");
        evt(1'b0, 1'b1, 1'b0); check_all("seq_r0");
        evt(1'b0, 1'b1, 1'b0); check_all("seq_r1");
        evt(1'b0, 1'b1, 1'b0); check_all("seq_r2");

        // frozen edges are lost
        evt(1'b1, 1'b0, 1'b0); check_all("pre_freeze");
        for (int i = 0; i < 5; i++) begin
            evt(1'b1, 1'b0, 1'b1);
            check_all($sformatf("freeze%0d", i));
        end

        // mid-operation reset, released with writer sync still high
        @(negedge clk);
        wr_sync = 1'b1;
        #2 rst_133 = 1'b1;
        #1 m_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_133 = 1'b0;
        repeat (10) @(negedge clk);
        check_all("release_high");
        wr_sync = 1'b0;
        repeat (5) @(negedge clk);
        evt(1'b1, 1'b0, 1'b0);
        check_all("after_release");

        for (int i = 0; i < 150; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (!w && !r) w = 1'b1;
            f = ($urandom_range(0, 7) == 0);
            evt(w, r, f);
            check_all($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
